// File: rtl/w5300_ready_timer.sv
// Times the W5300 PLL settle period after reset release; gates host CS and interrupt until ready.
// Optional macro W5300_READY_INT_GATE_EN adds an interrupt synchroniser and ready-masking.
module w5300_ready_timer #(
    parameter int unsigned PRESCALE_W   = 8,
    parameter int unsigned SETTLE_TICKS = 300,
    parameter int unsigned TICK_W       = 9
) (
    input  logic clk,
    input  logic trigger_reset,
    input  logic w5300_resetl,
    input  logic host_cs,
    input  logic clear_early,
    input  logic w5300_int_l,
    output logic w5300_ready,
    output logic host_cs_gated,
    output logic early_access,
    output logic int_l_gated
);

    typedef enum logic [1:0] {StHold, StSettle, StReady} state_e;

    localparam logic [TICK_W-1:0] LastTick = TICK_W'(SETTLE_TICKS - 1);

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [TICK_W-1:0]       ticks_q, ticks_d;
    logic                    early_q, early_d;

    always_ff @(posedge clk or posedge trigger_reset) begin
        if (trigger_reset) begin
            state_q <= StHold;
            presc_q <= '0;
            ticks_q <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ticks_q <= ticks_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        ticks_d = '0;
        case (state_q)
            StHold: begin
                if (w5300_resetl) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!w5300_resetl) begin
                    state_d = StHold;
                end else begin
                    presc_d = presc_q + PRESCALE_W'(1);
                    ticks_d = ticks_q;
                    if (&presc_q) begin
                        // Final tick: go ready with the tick counter parked at zero.
                        if (ticks_q == LastTick) begin
                            state_d = StReady;
                            ticks_d = '0;
                        end else begin
                            ticks_d = ticks_q + TICK_W'(1);
                        end
                    end
                end
            end
            StReady: begin
                if (!w5300_resetl) begin
                    state_d = StHold;
                end
            end
            default: state_d = StHold;
        endcase
    end

    // Set beats clear when both land on the same edge.
    always_comb begin
        early_d = early_q;
        if (host_cs && (state_q != StReady)) begin
            early_d = 1'b1;
        end else if (clear_early) begin
            early_d = 1'b0;
        end
    end

    assign w5300_ready   = (state_q == StReady);
    assign host_cs_gated = host_cs & w5300_ready;
    assign early_access  = early_q;

`ifdef W5300_READY_INT_GATE_EN
    logic [1:0] int_sync_q;

    always_ff @(posedge clk or posedge trigger_reset) begin
        if (trigger_reset) begin
            int_sync_q <= 2'b11;
        end else begin
            int_sync_q <= {int_sync_q[0], w5300_int_l};
        end
    end

    assign int_l_gated = int_sync_q[1] | ~w5300_ready;
`else
    assign int_l_gated = w5300_int_l;
`endif

endmodule

// File: tb/tb_w5300_ready_timer.sv
// Bench for w5300_ready_timer: directed scenarios plus random traffic against a run-length model.
module tb_w5300_ready_timer;

    localparam int unsigned PW = 2;
    localparam int unsigned ST = 3;
    localparam int unsigned TW = 2;
    localparam int unsigned SETTLE_EDGES = ST * (1 << PW);

    logic clk = 1'b0;
    logic trigger_reset, w5300_resetl, host_cs, clear_early, w5300_int_l;
    logic w5300_ready, host_cs_gated, early_access, int_l_gated;

    int vectors = 0;
    int miscompares = 0;

    // Model: ready once the count of consecutive high samples of resetl exceeds the settle length.
    int   run_m;
    logic ready_m, early_m, s1_m, s2_m;

    w5300_ready_timer #(
        .PRESCALE_W  (PW),
        .SETTLE_TICKS(ST),
        .TICK_W      (TW)
    ) dut (
        .clk          (clk),
        .trigger_reset(trigger_reset),
        .w5300_resetl (w5300_resetl),
        .host_cs      (host_cs),
        .clear_early  (clear_early),
        .w5300_int_l  (w5300_int_l),
        .w5300_ready  (w5300_ready),
        .host_cs_gated(host_cs_gated),
        .early_access (early_access),
        .int_l_gated  (int_l_gated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task model_reset();
        run_m   = 0;
        ready_m = 1'b0;
        early_m = 1'b0;
        s1_m    = 1'b1;
        s2_m    = 1'b1;
    endtask

    task model_edge();
        if (trigger_reset) begin
            model_reset();
        end else begin
            if (host_cs && !ready_m) early_m = 1'b1;
            else if (clear_early) early_m = 1'b0;
            s2_m = s1_m;
            s1_m = w5300_int_l;
            run_m = w5300_resetl ? ((run_m < 100000) ? run_m + 1 : run_m) : 0;
            ready_m = (run_m > SETTLE_EDGES);
        end
    endtask

    task check_all(input string tag);
        logic int_exp;
`ifdef W5300_READY_INT_GATE_EN
        int_exp = s2_m | ~ready_m;
`else
        int_exp = w5300_int_l;
`endif
        check({tag, ".ready"}, w5300_ready, ready_m);
        check({tag, ".cs_gated"}, host_cs_gated, host_cs & ready_m);
        check({tag, ".early"}, early_access, early_m);
        check({tag, ".int_l"}, int_l_gated, int_exp);
    endtask

    task step(input string tag, input logic rl, input logic hc, input logic ce, input logic il);
        w5300_resetl = rl;
        host_cs      = hc;
        clear_early  = ce;
        w5300_int_l  = il;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int rise;

        trigger_reset = 1'b1;
        w5300_resetl  = 1'b0;
        host_cs       = 1'b0;
        clear_early   = 1'b0;
        w5300_int_l   = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        trigger_reset = 1'b0;

        // Hold W5300 in reset for 31 cycles with random side inputs.
        for (int i = 0; i < 31; i++) begin
            step("hold", 1'b0, 1'(($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step("clr", 1'b0, 1'b0, 1'b1, 1'b1);

        // Release: ready must rise exactly SETTLE_EDGES edges after the first high sample.
        rise = 0;
        for (int i = 1; i <= int'(SETTLE_EDGES) + 3; i++) begin
            step("settle1", 1'b1, 1'b0, 1'b0, (i == 6) ? 1'b0 : 1'b1);
            if (w5300_ready && rise == 0) rise = i;
        end
        check_int("ready_edge", rise - 1, SETTLE_EDGES);

        // Re-reset at settle cycle 7 must restart the full period.
        step("drop0", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) step("pre", 1'b1, 1'b0, 1'b0, 1'b1);
        step("drop1", 1'b0, 1'b0, 1'b0, 1'b1);
        rise = 0;
        for (int i = 1; i <= int'(SETTLE_EDGES) + 2; i++) begin
            // Early host access at settle cycle 4; int pin low mid-settle.
            step("settle2", 1'b1, (i == 4), 1'b0, (i >= 5 && i <= 8) ? 1'b0 : 1'b1);
            if (i == 4) check("early_set", early_access, 1'b1);
            if (w5300_ready && rise == 0) rise = i;
        end
        check_int("rereset_edge", rise - 1, SETTLE_EDGES);

        // Once ready: CS passes straight through, early flag unaffected.
        for (int i = 0; i < 8; i++) begin
            step("ready_cs", 1'b1, 1'(i[0]), 1'b0, 1'b1);
        end
        check("early_kept", early_access, 1'b1);
        step("clear", 1'b1, 1'b0, 1'b1, 1'b1);
        check("early_clr", early_access, 1'b0);

        // Interrupt pin falls while ready.
        for (int i = 0; i < 4; i++) step("int_rdy", 1'b1, 1'b0, 1'b0, 1'b0);
        step("int_rel", 1'b1, 1'b0, 1'b0, 1'b1);

        // Set and clear on the same edge: set wins, then clear alone clears.
        step("sc_drop", 1'b0, 1'b0, 1'b0, 1'b1);
        step("sc_both", 1'b0, 1'b1, 1'b1, 1'b1);
        check("set_wins", early_access, 1'b1);
        step("sc_clear", 1'b0, 1'b0, 1'b1, 1'b1);
        check("clear_only", early_access, 1'b0);

        // Reach READY again, then pulse trigger_reset between clock edges.
        for (int i = 0; i < int'(SETTLE_EDGES) + 3; i++) step("settle3", 1'b1, 1'b0, 1'b0, 1'b1);
        check("ready_before_async", w5300_ready, 1'b1);
        host_cs     = 1'b1;
        w5300_int_l = 1'b0;
        step("prep", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        trigger_reset = 1'b1;
        #1;
        model_reset();
        check_all("async");
        @(posedge clk);
        #1;
        trigger_reset = 1'b0;

        // Random traffic with occasional reset drops and trigger pulses.
        for (int i = 0; i < 700; i++) begin
            if (i % 250 == 249) begin
                trigger_reset = 1'b1;
                step("rnd_trig", 1'b1, 1'b0, 1'b0, 1'b1);
                trigger_reset = 1'b0;
            end else begin
                step("rnd", 1'($urandom_range(0, 99) >= 3), 1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/w5300_ready_timer.md
# w5300_ready_timer

Sits directly downstream of the W5300 reset pulse generator in the QL expansion CPLD. It watches the W5300 active-low reset line and, after release, times the chip's PLL/internal settle period before declaring the W5300 ready. Until ready, it blocks host chip-selects and masks the W5300 interrupt toward the QL. Host accesses attempted too early are recorded in a sticky flag for driver diagnostics.

## Interface
- PRESCALE_W, 8: prescaler width; one settle tick = 2^PRESCALE_W clk cycles.
- SETTLE_TICKS, 300: ticks from reset release to ready (≥1); default ≈10.2 ms at 7.5 MHz.
- TICK_W, 9: tick counter width; must hold SETTLE_TICKS-1.

- clk  in  1  CPLD system clock; all state changes on rising edge.
- trigger_reset  in  1  asynchronous, active-high reset; the same signal that fires the reset pulse generator.
- w5300_resetl  in  1  active-low W5300 reset from the pulse generator, same clock domain.
- host_cs  in  1  decoded host access to the W5300 window.
- clear_early  in  1  single-cycle strobe that clears early_access.
- w5300_int_l  in  1  raw active-low W5300 interrupt pin.
- w5300_ready  out  1  high once the settle period has completed.
- host_cs_gated  out  1  host_cs & w5300_ready, combinational; drives the W5300 CS.
- early_access  out  1  sticky; host_cs seen while not ready.
- int_l_gated  out  1  interrupt toward the QL, active low.

## Operation
- States: HOLD, SETTLE, READY. Async trigger_reset forces HOLD and clears the prescaler, tick counter and early_access.
- HOLD: counters held at 0. When w5300_resetl is sampled high on a clk edge, go to SETTLE with prescaler=0 and ticks=0.
- SETTLE: prescaler increments every edge and wraps naturally. On the edge where prescaler is all ones, ticks increments. If ticks==SETTLE_TICKS-1 at that same point, go to READY.
- READY: stays until w5300_resetl is sampled low.
- From SETTLE or READY, w5300_resetl sampled low → HOLD on that edge, counters cleared. A mid-settle re-reset restarts the full period.
- w5300_ready = (state==READY), registered.
- early_access is set on any edge with host_cs=1 and state≠READY. clear_early clears it. If set and clear occur on the same edge, set wins. It is not cleared by w5300_resetl.
- Counter arithmetic is unsigned. The prescaler wraps modulo 2^PRESCALE_W. The tick counter never exceeds SETTLE_TICKS-1.

## Timing
- Reset values: w5300_ready 0, host_cs_gated 0, early_access 0, int_l_gated 1. State is HOLD.
- If SETTLE is entered at edge E, w5300_ready rises at edge E + SETTLE_TICKS·2^PRESCALE_W.
- w5300_resetl low at edge F → w5300_ready low after edge F (1-cycle latency).
- host_cs_gated has no added latency relative to host_cs once ready.
- early_access is visible the cycle after the offending host_cs.

## Configuration
- Macro: W5300_READY_INT_GATE_EN.
- Defined: w5300_int_l passes through a 2-flop synchroniser (reset value 1). int_l_gated = sync_int_l | ~w5300_ready, so assertion reaches the output 2 edges after the pin falls.
- Undefined: int_l_gated = w5300_int_l as a combinational passthrough. There are no synchroniser flops and no masking; drivers must then ignore interrupts until w5300_ready.

## Test plan
All scenarios use PRESCALE_W=2, SETTLE_TICKS=3, TICK_W=2.
- Pulse trigger_reset, hold w5300_resetl low 31 cycles, then release → w5300_ready rises exactly 12 edges after the first edge sampling w5300_resetl high.
- Drop w5300_resetl for 1 cycle at settle cycle 7, then release → ready rises 12 edges after re-entry, not 5.
- Assert host_cs at settle cycle 4 → host_cs_gated stays 0 and early_access=1 next cycle. Assert host_cs after ready → host_cs_gated follows host_cs and early_access is unchanged.
- Drive clear_early and an early host_cs on the same edge → early_access=1. Then clear_early alone → 0.
- With macro defined, drive w5300_int_l=0 during SETTLE → int_l_gated=1; after ready → int_l_gated=0 two edges after the pin fall. With macro undefined → int_l_gated tracks the pin immediately.
- Assert trigger_reset asynchronously mid-READY → all outputs return to reset values without a clk edge.
